// File: rtl/store_buffer.sv
// store_buffer
//   Posted-write FIFO between the MEM stage and the data-memory write port.
//   Word stores are queued and retired to DM one per cycle whenever no load
//   owns the DM port. Loads that match a buffered store get the youngest
//   matching data forwarded, so DM observes stores in program order.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   st_valid/ready    store handshake; st_addr/st_wd/st_pc4 store payload
//   ld_valid          load owns the DM port this cycle (blocks drain)
//   ld_addr           load address for forwarding compare
//   fwd_hit/fwd_data  youngest buffered match for ld_addr (data 0 on miss)
//   dm_we/a/wd/pc4    head entry presented to the DM write port
//   count, empty      occupancy
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_wd,
    input  logic [31:0]   st_pc4,
    input  logic          ld_valid,
    input  logic [31:0]   ld_addr,
    output logic          fwd_hit,
    output logic [31:0]   fwd_data,
    output logic          dm_we,
    output logic [31:0]   dm_a,
    output logic [31:0]   dm_wd,
    output logic [31:0]   dm_pc4,
    output logic [AW:0]   count,
    output logic          empty
);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pc4;
    } entry_t;

    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic          push, drain;
    entry_t        head;

    // Word compare only; the byte-offset bits of the load address never matter.
    logic          unused_ld_lsb;
    assign unused_ld_lsb = ^ld_addr[1:0];

    assign empty    = (count_q == '0);
    // Full depends only on occupancy, not on whether a drain happens this
    // cycle, so st_ready never combinationally depends on ld_valid.
    assign st_ready = (count_q != (AW+1)'(DEPTH));
    assign push     = st_valid && st_ready;
    assign dm_we    = !empty && !ld_valid;
    assign drain    = dm_we;
    assign count    = count_q;

    assign head   = ent_q[rd_ptr_q];
    assign dm_a   = empty ? 32'h0 : head.addr;
    assign dm_wd  = empty ? 32'h0 : head.wd;
    assign dm_pc4 = empty ? 32'h0 : head.pc4;

    always_comb begin
        ent_d    = ent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            ent_d[wr_ptr_q] = '{addr: st_addr, wd: st_wd, pc4: st_pc4};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (drain) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (AW+1)'(push) - (AW+1)'(drain);
    end

    // Walk entries oldest to youngest; a later match overrides an earlier one,
    // so the surviving value is the youngest store to that word.
    always_comb begin
        logic [AW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = 32'h0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + AW'(k);
            if (((AW+1)'(k) < count_q) && (ent_q[idx].addr[31:2] == ld_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_q[idx].wd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ent_q    <= ent_d;
        end
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the EX/MEM stage and the data memory (DM) write port. Word stores from the pipeline are queued in a small FIFO and retired to DM one per cycle whenever the DM port is not needed by a load. Loads that hit a pending store get the youngest matching data forwarded. DM contents therefore remain identical to program order.

## Interface
- DEPTH, 4, number of entries; power of 2, ≥2
- AW, 2, pointer width; log2(DEPTH)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- st_valid  in  1  store request from MEM stage this cycle
- st_ready  out  1  buffer can accept a store; equals (count != DEPTH)
- st_addr  in  32  byte address of store; bits [1:0] ignored (word stores only)
- st_wd  in  32  store data
- st_pc4  in  32  PC+4 of the store instruction, carried to DM for its write log
- ld_valid  in  1  a load uses the DM port this cycle (blocks drain)
- ld_addr  in  32  load byte address for forwarding compare
- fwd_hit  out  1  some buffered entry matches ld_addr[31:2]
- fwd_data  out  32  data of youngest matching entry; 0 when no hit
- dm_we  out  1  DM write enable
- dm_a  out  32  DM address (head entry st_addr)
- dm_wd  out  32  DM write data (head entry)
- dm_pc4  out  32  head entry st_pc4, to DM PC_4 input
- count  out  AW+1  number of valid entries
- empty  out  1  count == 0

## Operation
- Storage: DEPTH entries of {addr[31:0], wd[31:0], pc4[31:0]}, circular; head pointer rd_ptr, tail pointer wr_ptr (AW bits each, wrap modulo DEPTH), count register AW+1 bits.
- Push: st_valid && st_ready at posedge → entry written at wr_ptr, wr_ptr+1. st_valid while full is ignored (no write, no pointer change); the pipeline must stall on !st_ready.
- Drain: dm_we = !empty && !ld_valid (combinational). dm_a/dm_wd/dm_pc4 always show the head entry; 0 when empty. At posedge with dm_we=1, DM writes and rd_ptr+1.
- Simultaneous push and drain: both happen; count unchanged. Allowed at any count < DEPTH. At count == DEPTH a push is refused even if a drain occurs that cycle (st_ready is not a function of dm_we).
- count next = count + push − drain; never exceeds DEPTH nor goes below 0.
- Forwarding: compare ld_addr[31:2] against addr[31:2] of every valid entry; fwd_hit if any match; fwd_data = entry closest to tail (youngest). Compare covers buffered entries only, not the store presented on st_* in the same cycle. Forwarding is evaluated regardless of ld_valid.
- No byte/halfword support; no flush input (queued stores are architecturally committed).

## Timing
- Reset (reset=0, asynchronous): rd_ptr=wr_ptr=0, count=0 → empty=1, st_ready=1, dm_we=0, dm_a=dm_wd=dm_pc4=0, fwd_hit=0, fwd_data=0. Stored entries may keep stale contents but are invalid.
- Reset asserted mid-operation discards all pending stores immediately; none reach DM after reset is asserted.
- Latency: store accepted at edge N → appears at head after N → written to DM at edge N+1 if ld_valid=0 in cycle N..N+1; each cycle with ld_valid=1 adds one cycle.
- Forwarding visible the cycle after the store is accepted, until the edge at which it drains.
- All outputs except registered pointers/count are combinational from registers and ld_* inputs; no st_* → dm_* combinational path.

## Test plan
- Reset: hold reset=0 two cycles, release → count=0, empty=1, st_ready=1, dm_we=0, fwd_hit=0.
- Single store: st_addr=0x0000_0010, st_wd=0xDEADBEEF, st_pc4=0x0000_3004 at edge 1, ld_valid=0 → cycle after: dm_we=1, dm_a=0x10, dm_wd=0xDEADBEEF, dm_pc4=0x3004; after edge 2 empty=1.
- Load blocking + forwarding: two stores to 0x20 (0x11111111 then 0x22222222), ld_valid=1 ld_addr=0x23 held → dm_we=0, count=2, fwd_hit=1, fwd_data=0x22222222; drop ld_valid → drains 0x11111111 then 0x22222222 in order.
- Full: ld_valid=1, push 5 stores with DEPTH=4 → st_ready=0 after 4th, 5th ignored, count=4; release ld_valid → exactly 4 DM writes in order.
- Wrap-around with concurrent push/drain: 10 back-to-back stores, ld_valid=0 → count steady at 1, DM writes match push order, pointers wrap past 3→0.
- Reset mid-operation: 3 entries queued, assert reset between edges → dm_we=0 and count=0 immediately, no further DM writes.
